pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Combines four requests: the load-use stall from the forwarding/hazard unit, the branch/jump redirect resolved in EX, the multi-cycle divider handshake, and the data-memory wait.
- Drives per-stage hold and bubble controls, the PC redirect, and a stall performance counter.
- Sits beside the IDU/EXU/MEM stage registers.

Parameters:
XLEN, 32, datapath/address width
DIV_TIMEOUT, 64, max DIV_WAIT cycles before forced release (>=2)
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
load_hazerd_stall  in  1  load-use hazard from hazard unit
jump_en_ex  in  1  taken branch/jump resolved in EX
jump_addr_ex  in  XLEN  redirect target
div_req_ex  in  1  EX holds a valid div/rem instruction
div_done  in  1  divider result valid (1-cycle pulse)
dmem_req_mem  in  1  MEM stage issuing a data-memory access
dmem_ready  in  1  data memory completes access this cycle
stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold PC / IF-ID / ID-EX / EX-MEM register
flush_id, flush_ex, flush_mem, flush_wb  out  1 each  load bubble into IF-ID / ID-EX / EX-MEM / MEM-WB
pc_redirect  out  1  load PC from redirect_addr
redirect_addr  out  XLEN  redirect target
div_start  out  1  1-cycle divider start pulse
div_timeout_err  out  1  sticky divider-timeout flag
stall_cnt  out  CNT_W  lost-cycle counter

Behaviour:
- State register: RUN, DIV_WAIT, MEM_WAIT. Control outputs are combinational from state and inputs.
- All control outputs are 0 whenever rst=1. redirect_addr is 0 when pc_redirect=0.
- At reset: state=RUN, div timer=0, div_timeout_err=0, stall_cnt=0.
- RUN priority, highest first; only one rule applies per cycle:
  1. dmem_req_mem & !dmem_ready: stall_if/id/ex/mem=1, flush_wb=1; next MEM_WAIT. jump_en_ex is ignored this cycle; the frozen EX re-presents it later.
  2. div_req_ex: div_start=1, stall_if/id/ex=1, flush_mem=1; timer<=0; next DIV_WAIT.
  3. jump_en_ex: pc_redirect=1, redirect_addr=jump_addr_ex, flush_id=1, flush_ex=1; stay RUN. Overrides load_hazerd_stall, because the ID instruction is squashed.
  4. load_hazerd_stall: stall_if=1, stall_id=1, flush_ex=1; stay RUN.
  5. Otherwise: all controls 0.
- MEM_WAIT:
  - dmem_ready=0: same outputs as RUN rule 1; stay.
  - dmem_ready=1: evaluate RUN rules 2-5 this cycle (memory no longer blocks); next state per those rules.
- DIV_WAIT:
  - div_done=0 and timer<DIV_TIMEOUT-1: stall_if/id/ex=1, flush_mem=1, div_start=0; timer++.
  - div_done=1: no stall/flush; EX result advances into EX-MEM; next RUN.
  - div_done=0 and timer==DIV_TIMEOUT-1: forced release, outputs as for div_done; div_timeout_err<=1; next RUN.
  - jump_en_ex and load_hazerd_stall are ignored in DIV_WAIT (EX holds a divide, not a branch or load).
  - MEM holds a bubble, so dmem_req_mem=0 is expected. If it is asserted anyway, it is ignored.
- div_timeout_err: sticky, cleared only by rst.
- div_start: never asserted in DIV_WAIT. A div following a div produces a new pulse from RUN.
- stall_cnt: +1 on every cycle with any stall_* =1, or with flush_ex=1 from rule 4. Saturates at all-ones. Redirect cycles are not counted.
- Reset mid-operation: the next cycle is RUN with counters cleared. No pending div_start or redirect is replayed.

Test Plan:
- load_hazerd_stall=1 for 1 cycle in RUN -> that cycle stall_if=stall_id=flush_ex=1, other controls 0; stall_cnt 0->1.
- jump_en_ex=1, jump_addr_ex=0x0000_0100, load_hazerd_stall=1 same cycle -> pc_redirect=1, redirect_addr=0x100, flush_id=flush_ex=1, stall_id=0; stall_cnt unchanged.
- div_req_ex=1, div_done pulses on 5th DIV_WAIT cycle -> div_start=1 for exactly 1 cycle. Stalls asserted 5 cycles (RUN entry + 4 DIV_WAIT), released on the done cycle, state RUN; stall_cnt +5.
- dmem_req_mem=1, dmem_ready=0 for 3 cycles with jump_en_ex=1, addr 0x200 -> 3 cycles full freeze + flush_wb, pc_redirect=0. On the dmem_ready=1 cycle: pc_redirect=1, redirect_addr=0x200.
- DIV_TIMEOUT=8, div_req_ex=1, div_done never -> stalls for the entry cycle + 7 DIV_WAIT cycles, released on the 8th DIV_WAIT cycle. div_timeout_err=1 from the next cycle and stays 1 across later divs.
- rst=1 on the 3rd DIV_WAIT cycle -> all controls 0; following cycle state RUN, div_timeout_err=0, stall_cnt=0, div_start=0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Ports: hazard/jump/div/dmem requests in; stage holds, bubbles, redirect, div_start, stall_cnt out.
module pipe_ctrl #(
  parameter int XLEN        = 32,
  parameter int DIV_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_hazerd_stall,
  input  logic             jump_en_ex,
  input  logic [XLEN-1:0]  jump_addr_ex,
  input  logic             div_req_ex,
  input  logic             div_done,
  input  logic             dmem_req_mem,
  input  logic             dmem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             flush_mem,
  output logic             flush_wb,
  output logic             pc_redirect,
  output logic [XLEN-1:0]  redirect_addr,
  output logic             div_start,
  output logic             div_timeout_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TW = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(DIV_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_DIV,
    S_MEM
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [TW-1:0]    r_timer;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic w_run_eval;
  logic w_freeze;
  logic w_timer_clr;
  logic w_timer_inc;
  logic w_set_err;
  logic w_stall_any;

  always_comb begin
    w_next      = r_state;
    w_run_eval  = 1'b0;
    w_freeze    = 1'b0;
    w_timer_clr = 1'b0;
    w_timer_inc = 1'b0;
    w_set_err   = 1'b0;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    stall_mem   = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    flush_mem   = 1'b0;
    flush_wb    = 1'b0;
    pc_redirect = 1'b0;
    div_start   = 1'b0;

    unique case (r_state)
      S_RUN: begin
        if (dmem_req_mem && !dmem_ready) begin
          w_freeze = 1'b1;
          w_next   = S_MEM;
        end else begin
          w_run_eval = 1'b1;
        end
      end
      S_MEM: begin
        // Frozen MEM keeps its request; only ready releases it.
        if (!dmem_ready) begin
          w_freeze = 1'b1;
        end else begin
          w_run_eval = 1'b1;
        end
      end
      S_DIV: begin
        if (div_done) begin
          w_next = S_RUN;
        end else if (r_timer == TMAX) begin
          w_set_err = 1'b1;
          w_next    = S_RUN;
        end else begin
          stall_if    = 1'b1;
          stall_id    = 1'b1;
          stall_ex    = 1'b1;
          flush_mem   = 1'b1;
          w_timer_inc = 1'b1;
        end
      end
      default: w_next = S_RUN;
    endcase

    if (w_freeze) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
      flush_wb  = 1'b1;
    end

    if (w_run_eval) begin
      w_next = S_RUN;
      if (div_req_ex) begin
        div_start   = 1'b1;
        stall_if    = 1'b1;
        stall_id    = 1'b1;
        stall_ex    = 1'b1;
        flush_mem   = 1'b1;
        w_timer_clr = 1'b1;
        w_next      = S_DIV;
      end else if (jump_en_ex) begin
        // ID is squashed, so a load-use hazard there is moot.
        pc_redirect = 1'b1;
        flush_id    = 1'b1;
        flush_ex    = 1'b1;
      end else if (load_hazerd_stall) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
    end

    if (rst) begin
      stall_if    = 1'b0;
      stall_id    = 1'b0;
      stall_ex    = 1'b0;
      stall_mem   = 1'b0;
      flush_id    = 1'b0;
      flush_ex    = 1'b0;
      flush_mem   = 1'b0;
      flush_wb    = 1'b0;
      pc_redirect = 1'b0;
      div_start   = 1'b0;
    end
  end

  assign redirect_addr   = pc_redirect ? jump_addr_ex : '0;
  assign div_timeout_err = r_err & ~rst;
  assign stall_cnt       = r_cnt;
  assign w_stall_any     = stall_if | stall_id | stall_ex | stall_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_timer <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_timer_clr) begin
        r_timer <= '0;
      end else if (w_timer_inc) begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_set_err) begin
        r_err <= 1'b1;
      end
      if (w_stall_any && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: self-checking bench for pipe_ctrl.
// Directed scenarios plus random stimulus against a behavioural model.
module tb_pipe_ctrl;

  localparam int XLEN = 32;
  localparam int DT   = 8;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  localparam int M_RUN = 0;
  localparam int M_DIV = 1;
  localparam int M_MEM = 2;

  // {sif,sid,sex,smem,fid,fex,fmem,fwb,pcr,dst}
  localparam logic [9:0] C_FREEZE = 10'b1111000100;
  localparam logic [9:0] C_DHOLD  = 10'b1110001000;
  localparam logic [9:0] C_DSTART = 10'b1110001001;
  localparam logic [9:0] C_REDIR  = 10'b0000110010;
  localparam logic [9:0] C_LU     = 10'b1100010000;

  logic clk = 1'b0;
  logic rst;
  logic lh, je, dq, dd, mq, mr;
  logic [XLEN-1:0] ja;

  logic sif, sid, sex, smem, fid, fex, fmem, fwb, pcr, dst, err;
  logic [XLEN-1:0] raddr;
  logic [CW-1:0] cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .XLEN(XLEN),
    .DIV_TIMEOUT(DT),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load_hazerd_stall(lh),
    .jump_en_ex(je),
    .jump_addr_ex(ja),
    .div_req_ex(dq),
    .div_done(dd),
    .dmem_req_mem(mq),
    .dmem_ready(mr),
    .stall_if(sif),
    .stall_id(sid),
    .stall_ex(sex),
    .stall_mem(smem),
    .flush_id(fid),
    .flush_ex(fex),
    .flush_mem(fmem),
    .flush_wb(fwb),
    .pc_redirect(pcr),
    .redirect_addr(raddr),
    .div_start(dst),
    .div_timeout_err(err),
    .stall_cnt(cnt)
  );

  wire [9:0] act = {sif, sid, sex, smem, fid, fex, fmem, fwb, pcr, dst};

  int n_cmp = 0;
  int n_bad = 0;

  int m_mode = M_RUN;
  int m_wait = 0;
  bit m_err  = 1'b0;
  int m_cnt  = 0;

  logic [9:0]      e_ctrl;
  logic [XLEN-1:0] e_addr;
  logic [CW-1:0]   e_cnt;
  logic            e_err;

  task automatic drive(input logic r, input logic l, input logic j,
                       input logic [XLEN-1:0] a, input logic q,
                       input logic d, input logic mrq, input logic mrd);
    bit frz;
    rst = r; lh = l; je = j; ja = a;
    dq = q; dd = d; mq = mrq; mr = mrd;
    #1;
    e_ctrl = '0;
    e_addr = '0;
    frz = (m_mode == M_MEM) ? !mrd : (m_mode == M_RUN && mrq && !mrd);
    if (!r) begin
      if (frz) e_ctrl = C_FREEZE;
      else if (m_mode == M_DIV) begin
        if (!d && m_wait < DT - 1) e_ctrl = C_DHOLD;
      end
      else if (q) e_ctrl = C_DSTART;
      else if (j) begin
        e_ctrl = C_REDIR;
        e_addr = a;
      end
      else if (l) e_ctrl = C_LU;
    end
    e_cnt = CW'(m_cnt);
    e_err = r ? 1'b0 : m_err;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_mode = M_RUN; m_wait = 0; m_err = 1'b0; m_cnt = 0;
    end else begin
      if (e_ctrl[9:6] != 0 && m_cnt < CMAX) m_cnt++;
      case (m_mode)
        M_RUN: begin
          if (mq && !mr) m_mode = M_MEM;
          else if (dq) begin m_mode = M_DIV; m_wait = 0; end
        end
        M_MEM: begin
          if (mr) begin
            if (dq) begin m_mode = M_DIV; m_wait = 0; end
            else m_mode = M_RUN;
          end
        end
        default: begin
          if (dd) m_mode = M_RUN;
          else if (m_wait == DT - 1) begin m_mode = M_RUN; m_err = 1'b1; end
          else m_wait++;
        end
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 32'hdead_beef, 1, 1, 1, 0);
    n_cmp++;
    if (act !== 10'b0 || raddr !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: ctrl=%b addr=%h want 0", act, raddr);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (act !== 10'b0 || cnt !== 4'd0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: ctrl=%b cnt=%0d err=%b want 0", act, cnt, err);
    end
    tick();
  endtask

  task automatic test_load_use();
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (act !== e_ctrl || act !== C_LU || cnt !== e_cnt) begin
      n_bad++;
      $display("FAIL load_use: ctrl=%b/%b cnt=%0d/%0d", act, e_ctrl, cnt, e_cnt);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (cnt !== e_cnt || cnt !== 4'd1 || act !== e_ctrl) begin
      n_bad++;
      $display("FAIL load_use_cnt: cnt=%0d want %0d ctrl=%b", cnt, e_cnt, act);
    end
    tick();
  endtask

  task automatic test_jump_over_load();
    drive(0, 1, 1, 32'h0000_0100, 0, 0, 0, 0);
    n_cmp++;
    if (act !== e_ctrl || raddr !== 32'h100 || sid !== 1'b0) begin
      n_bad++;
      $display("FAIL jump_load: ctrl=%b/%b addr=%h/%h", act, e_ctrl, raddr, e_addr);
    end
    tick();
    drive(0, 0, 0, 32'h0000_0100, 0, 0, 0, 0);
    n_cmp++;
    if (cnt !== e_cnt || raddr !== '0) begin
      n_bad++;
      $display("FAIL jump_cnt: cnt=%0d/%0d addr=%h", cnt, e_cnt, raddr);
    end
    tick();
  endtask

  task automatic test_div_done();
    int starts = 0;
    int stalls = 0;
    for (int k = 0; k <= 6; k++) begin
      drive(0, k == 3, k == 2, 32'h44, k < 6, k == 5, 0, 0);
      n_cmp++;
      if (act !== e_ctrl || raddr !== e_addr || cnt !== e_cnt) begin
        n_bad++;
        $display("FAIL div_done c%0d: ctrl=%b/%b cnt=%0d/%0d", k, act, e_ctrl, cnt, e_cnt);
      end
      starts += dst;
      stalls += sif;
      tick();
    end
    n_cmp++;
    if (starts != 1 || stalls != 5) begin
      n_bad++;
      $display("FAIL div_pulses: starts=%0d want 1 stalls=%0d want 5", starts, stalls);
    end
  endtask

  task automatic test_mem_wait_jump();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 32'h0000_0200, 0, 0, 1, k == 3);
      n_cmp++;
      if (act !== e_ctrl || raddr !== e_addr || cnt !== e_cnt) begin
        n_bad++;
        $display("FAIL mem_jump c%0d: ctrl=%b/%b addr=%h/%h", k, act, e_ctrl, raddr, e_addr);
      end
      if (k == 3) begin
        n_cmp++;
        if (pcr !== 1'b1 || raddr !== 32'h200) begin
          n_bad++;
          $display("FAIL mem_release: pcr=%b addr=%h want 1/200", pcr, raddr);
        end
      end
      tick();
    end
  endtask

  task automatic test_div_timeout();
    for (int k = 0; k <= 9; k++) begin
      drive(0, 0, 0, 0, k < 9, 0, 0, 0);
      n_cmp++;
      if (act !== e_ctrl || err !== e_err || cnt !== e_cnt) begin
        n_bad++;
        $display("FAIL div_tmo c%0d: ctrl=%b/%b err=%b/%b", k, act, e_ctrl, err, e_err);
      end
      tick();
    end
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_sticky: err=%b want 1", err);
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, k < 3, k == 2, 0, 0);
      n_cmp++;
      if (act !== e_ctrl || err !== 1'b1 || cnt !== e_cnt) begin
        n_bad++;
        $display("FAIL div_again c%0d: ctrl=%b/%b err=%b", k, act, e_ctrl, err);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_div();
    for (int k = 0; k < 4; k++) begin
      drive(k == 3, 0, 0, 0, 1, 0, 0, 0);
      n_cmp++;
      if (act !== e_ctrl) begin
        n_bad++;
        $display("FAIL rst_div c%0d: ctrl=%b/%b", k, act, e_ctrl);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (act !== 10'b0 || cnt !== 4'd0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_div_after: ctrl=%b cnt=%0d err=%b", act, cnt, err);
    end
    tick();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 20; k++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (act !== e_ctrl || cnt !== e_cnt) begin
        n_bad++;
        $display("FAIL sat c%0d: cnt=%0d/%0d", k, cnt, e_cnt);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (cnt !== 4'hf) begin
      n_bad++;
      $display("FAIL sat_final: cnt=%0d want 15", cnt);
    end
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      drive($urandom_range(49) == 0, $urandom_range(2) == 0,
            $urandom_range(2) == 0, $urandom,
            $urandom_range(3) == 0, $urandom_range(4) == 0,
            $urandom_range(2) == 0, $urandom_range(1) == 0);
      n_cmp++;
      if (act !== e_ctrl || raddr !== e_addr ||
          cnt !== e_cnt || err !== e_err) begin
        n_bad++;
        $display("FAIL rand c%0d: ctrl=%b/%b addr=%h/%h cnt=%0d/%0d err=%b/%b",
                 k, act, e_ctrl, raddr, e_addr, cnt, e_cnt, err, e_err);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_jump_over_load();
    test_div_done();
    test_mem_wait_jump();
    test_div_timeout();
    test_reset_mid_div();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
